// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: default width, FSM state
// encoding, result constants and the packed result record.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  // FSM state encoding, kept as plain constants so older blocks that compare
  // raw two-bit state codes keep working.
  typedef logic [1:0] div_state_t;

  localparam div_state_t IDLE = 2'd0;
  localparam div_state_t CALC = 2'd1;
  localparam div_state_t FIX  = 2'd2;
  localparam div_state_t DONE = 2'd3;

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

  // Most negative signed value; dividing it by -1 is the signed overflow case.
  localparam logic [DIV_WIDTH-1:0] SIGNED_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  // One complete division result as it is written to LO/HI plus its flags.
  typedef struct packed {
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 div_by_zero;
    logic                 overflow;
  } div_result_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift the partial
// remainder left, bring in the next dividend bit and keep the difference
// only if the trial subtraction did not go negative.
module div_step import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] abs_divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Trial subtraction carried one bit wider so its sign bit shows a borrow.
  always_comb begin
    shifted = {rem_in, q_msb};
    trial   = shifted - {2'b00, abs_divisor};
    if (!trial[WIDTH+1]) begin
      rem_out = trial[WIDTH:0];
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted[WIDTH:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned divider beside the ALU in EX. Operands are
// captured on start, divided as magnitudes one bit per clock, then sign
// corrected; quotient feeds LO and remainder feeds HI.
module iter_divider import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t       state;
  div_state_t       next_state;
  logic [CW-1:0]    count;

  // Operands as captured on the accepted start edge.
  logic             op_signed;
  logic [WIDTH-1:0] dvd_raw;
  logic [WIDTH-1:0] dvs_raw;
  logic [WIDTH-1:0] abs_dvs;

  // Partial remainder (one guard bit) and quotient shift register.
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] quo_reg;

  logic [WIDTH:0]   step_rem;
  logic             step_bit;
  logic             accept;
  logic [WIDTH-1:0] abs_dividend_in;
  logic [WIDTH-1:0] abs_divisor_in;
  div_result_t      fixed;

  assign busy   = (state == CALC) || (state == FIX);
  assign done   = (state == DONE);
  assign accept = start && ((state == IDLE) || (state == DONE));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in      (rem_reg),
    .q_msb       (quo_reg[WIDTH-1]),
    .abs_divisor (abs_dvs),
    .rem_out     (step_rem),
    .q_bit       (step_bit)
  );

  // Magnitudes of the incoming operands; -SIGNED_MIN stays SIGNED_MIN, which
  // read as unsigned is exactly the magnitude we need.
  always_comb begin
    abs_dividend_in = dividend;
    abs_divisor_in  = divisor;
    if (signed_op && dividend[WIDTH-1]) begin
      abs_dividend_in = -dividend;
    end
    if (signed_op && divisor[WIDTH-1]) begin
      abs_divisor_in = -divisor;
    end
  end

  // Final result: sign correction of the magnitudes, then the special cases
  // override; a zero magnitude negates to zero so no extra guard is needed.
  always_comb begin
    fixed.quotient    = quo_reg;
    fixed.remainder   = rem_reg[WIDTH-1:0];
    fixed.div_by_zero = 1'b0;
    fixed.overflow    = 1'b0;
    if (op_signed && (dvd_raw[WIDTH-1] ^ dvs_raw[WIDTH-1])) begin
      fixed.quotient = -quo_reg;
    end
    if (op_signed && dvd_raw[WIDTH-1]) begin
      fixed.remainder = -rem_reg[WIDTH-1:0];
    end
    if (dvs_raw == '0) begin
      fixed.quotient    = DBZ_QUOTIENT;
      fixed.remainder   = dvd_raw;
      fixed.div_by_zero = 1'b1;
    end else if (op_signed && (dvd_raw == SIGNED_MIN) && (dvs_raw == '1)) begin
      fixed.quotient  = SIGNED_MIN;
      fixed.remainder = '0;
      fixed.overflow  = 1'b1;
    end
  end

  // Next-state selection; DONE behaves like IDLE so a start there chains on.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? CALC : IDLE;
      CALC:    next_state = (count == LAST_STEP) ? FIX : CALC;
      FIX:     next_state = DONE;
      DONE:    next_state = start ? CALC : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operand capture and the per-clock restoring iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      op_signed <= 1'b0;
      dvd_raw   <= '0;
      dvs_raw   <= '0;
      abs_dvs   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
    end else if (accept) begin
      count     <= '0;
      op_signed <= signed_op;
      dvd_raw   <= dividend;
      dvs_raw   <= divisor;
      abs_dvs   <= abs_divisor_in;
      rem_reg   <= '0;
      quo_reg   <= abs_dividend_in;
    end else if (state == CALC) begin
      count   <= count + 1'b1;
      rem_reg <= step_rem;
      quo_reg <= {quo_reg[WIDTH-2:0], step_bit};
    end
  end

  // Visible results change only in FIX and otherwise hold for LO/HI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (state == FIX) begin
      quotient    <= fixed.quotient;
      remainder   <= fixed.remainder;
      div_by_zero <= fixed.div_by_zero;
      overflow    <= fixed.overflow;
    end
  end

endmodule
